// File: rtl/riscv_decode_stage_if.sv
// riscv_decode_stage_if: fetch-side and execute-side handshakes plus the decoded control bundle
interface riscv_decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] pc_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [31:0]     imm_o;
  logic [3:0]      alu_op_o;
  logic            alu_src_imm_o;
  logic            reg_write_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic [2:0]      mem_funct3_o;
  logic            branch_o;
  logic            jal_o;
  logic            jalr_o;
  logic            lui_o;
  logic            auipc_o;
  logic            illegal_o;
  modport slave (
    input  in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, rs1_o, rs2_o, rd_o, imm_o, alu_op_o, alu_src_imm_o,
           reg_write_o, mem_read_o, mem_write_o, mem_funct3_o, branch_o, jal_o, jalr_o,
           lui_o, auipc_o, illegal_o
  );
  modport master (
    output in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, rs1_o, rs2_o, rd_o, imm_o, alu_op_o, alu_src_imm_o,
           reg_write_o, mem_read_o, mem_write_o, mem_funct3_o, branch_o, jal_o, jalr_o,
           lui_o, auipc_o, illegal_o
  );
endinterface

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: RV32I decode into a 2-entry skid buffer; define RISCV_SHIFT_OPS_EN to decode shifts
module riscv_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  riscv_decode_stage_if.slave  bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [3:0]      alu_op;
    logic            alu_src_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_funct3;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            lui;
    logic            auipc;
    logic            illegal;
  } bundle_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_zero;
  logic        f7_alt;
  logic        f3_slt;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [3:0]  alu_f3;
  logic        shift_bad_reg;
  logic        shift_bad_imm;
  logic        ill_reg;
  logic        ill_imm;
  bundle_t     dec;
  bundle_t     head;
  bundle_t     tail;
  state_t      state;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        in_acc;
  logic        out_acc;
  assign ins     = bus.instr_i;
  assign opc     = ins[6:0];
  assign f3      = ins[14:12];
  assign f7      = ins[31:25];
  assign f7_zero = f7 == 7'b0000000;
  assign f7_alt  = f7 == 7'b0100000;
  assign f3_slt  = f3 == 3'b010 || f3 == 3'b011;
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
`ifdef RISCV_SHIFT_OPS_EN
  assign alu_f3 = f3 == 3'b100 ? ALU_XOR :
                  f3 == 3'b110 ? ALU_OR  :
                  f3 == 3'b111 ? ALU_AND :
                  f3 == 3'b001 ? 4'b0101 :
                  f3 == 3'b101 ? (f7_alt ? 4'b0111 : 4'b0110) : ALU_ADD;
  // register shifts are already policed by the funct7 checks below
  assign shift_bad_reg = 1'b0;
  assign shift_bad_imm = f3 == 3'b001 ? !f7_zero :
                         f3 == 3'b101 ? !(f7_zero || f7_alt) : 1'b0;
`else
  logic is_shift;
  assign is_shift = f3 == 3'b001 || f3 == 3'b101;
  assign alu_f3 = f3 == 3'b100 ? ALU_XOR :
                  f3 == 3'b110 ? ALU_OR  :
                  f3 == 3'b111 ? ALU_AND : ALU_ADD;
  assign shift_bad_reg = is_shift;
  assign shift_bad_imm = is_shift;
`endif
  assign ill_reg = !(f7_zero || f7_alt) || (f7_alt && !(f3 == 3'b000 || f3 == 3'b101)) ||
                   f3_slt || shift_bad_reg;
  assign ill_imm = f3_slt || shift_bad_imm;
  // combinational decode of the offered word; illegal entries lose every side-effect enable
  always_comb begin
    dec            = '0;
    dec.pc         = bus.pc_i;
    dec.rs1        = ins[19:15];
    dec.rs2        = ins[24:20];
    dec.rd         = ins[11:7];
    dec.mem_funct3 = f3;
    dec.alu_op     = ALU_ADD;
    case (opc)
      OP_LUI: begin
        dec.imm = imm_u;
        dec.rs1 = '0;
        dec.alu_src_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.lui = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm = imm_u;
        dec.alu_src_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.auipc = 1'b1;
      end
      OP_JAL: begin
        dec.imm = imm_j;
        dec.alu_src_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.jal = 1'b1;
      end
      OP_JALR: begin
        dec.imm = imm_i;
        dec.alu_src_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.jalr = 1'b1;
        dec.illegal = f3 != 3'b000;
      end
      OP_BRANCH: begin
        dec.imm = imm_b;
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
        dec.illegal = f3_slt;
      end
      OP_LOAD: begin
        dec.imm = imm_i;
        dec.alu_src_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read = 1'b1;
        dec.illegal = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        dec.imm = imm_s;
        dec.alu_src_imm = 1'b1;
        dec.mem_write = 1'b1;
        dec.illegal = f3 > 3'b010;
      end
      OP_IMM: begin
        dec.imm = imm_i;
        dec.alu_src_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op = alu_f3;
        dec.illegal = ill_imm;
      end
      OP_REG: begin
        dec.reg_write = 1'b1;
        dec.alu_op = (f3 == 3'b000 && f7_alt) ? ALU_SUB : alu_f3;
        dec.illegal = ill_reg;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jal       = 1'b0;
      dec.jalr      = 1'b0;
    end
  end
  assign in_acc  = bus.in_valid_i && in_ready_q;
  assign out_acc = out_valid_q && bus.out_ready_i;
  // skid FSM: head drives the outputs, tail catches the word taken while the head is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head        <= '0;
      tail        <= '0;
    end else if (flush_i) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (in_acc) begin
          head        <= dec;
          state       <= ONE;
          out_valid_q <= 1'b1;
        end
        ONE: if (in_acc && out_acc) begin
          head <= dec;
        end else if (in_acc) begin
          tail       <= dec;
          state      <= TWO;
          in_ready_q <= 1'b0;
        end else if (out_acc) begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
        end
        TWO: if (out_acc) begin
          head       <= tail;
          state      <= ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
  assign bus.in_ready_o    = in_ready_q;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.pc_o          = head.pc;
  assign bus.rs1_o         = head.rs1;
  assign bus.rs2_o         = head.rs2;
  assign bus.rd_o          = head.rd;
  assign bus.imm_o         = head.imm;
  assign bus.alu_op_o      = head.alu_op;
  assign bus.alu_src_imm_o = head.alu_src_imm;
  assign bus.reg_write_o   = head.reg_write;
  assign bus.mem_read_o    = head.mem_read;
  assign bus.mem_write_o   = head.mem_write;
  assign bus.mem_funct3_o  = head.mem_funct3;
  assign bus.branch_o      = head.branch;
  assign bus.jal_o         = head.jal;
  assign bus.jalr_o        = head.jalr;
  assign bus.lui_o         = head.lui;
  assign bus.auipc_o       = head.auipc;
  assign bus.illegal_o     = head.illegal;
endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage: directed checks of decode, skid handshake, reset and flush
module tb_riscv_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int nvec = 0;
  int nerr = 0;
  riscv_decode_stage_if #(.XLEN(32)) bus();
  riscv_decode_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(bus));
  always #5 clk = ~clk;
  // offer one word from a negedge, drop valid after the accepting edge, return at the next negedge
  task automatic offer(input logic [31:0] ins, input logic [31:0] p);
    bus.in_valid_i = 1'b1;
    bus.instr_i = ins;
    bus.pc_i = p;
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.instr_i = '0;
    bus.pc_i = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin
      nerr++; $display("FAIL reset_hs got %b exp 01", {bus.out_valid_o, bus.in_ready_o});
    end
    nvec++;
    if ({bus.pc_o, bus.imm_o, bus.rd_o, bus.alu_op_o, bus.reg_write_o, bus.illegal_o} !== 75'd0) begin
      nerr++; $display("FAIL reset_bundle got pc %h imm %h exp 0", bus.pc_o, bus.imm_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    offer(32'h00B50533, 32'h200);
    nvec++;
    if ({bus.out_valid_o, bus.pc_o} !== {1'b1, 32'h200}) begin
      nerr++; $display("FAIL reset_pre got v%b pc %h exp v1 pc 00000200", bus.out_valid_o, bus.pc_o);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({bus.out_valid_o, bus.in_ready_o, bus.pc_o} !== {2'b01, 32'h0}) begin
      nerr++; $display("FAIL reset_async got v%b r%b pc %h exp v0 r1 pc 0", bus.out_valid_o, bus.in_ready_o, bus.pc_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    nvec++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin
      nerr++; $display("FAIL reset_release got %b exp 01", {bus.out_valid_o, bus.in_ready_o});
    end
    offer(32'h00B50533, 32'h100);
    nvec++;
    if ({bus.out_valid_o, bus.pc_o} !== {1'b1, 32'h100}) begin
      nerr++; $display("FAIL reset_first got v%b pc %h exp v1 pc 00000100", bus.out_valid_o, bus.pc_o);
    end
  endtask
  task automatic test_decode;
    bus.out_ready_i = 1'b1;
    offer(32'h00B50533, 32'h100);
    nvec++;
    if ({bus.alu_op_o, bus.rs1_o, bus.rs2_o, bus.rd_o, bus.reg_write_o, bus.alu_src_imm_o, bus.illegal_o,
         bus.mem_read_o, bus.mem_write_o} !== {4'h0, 5'd10, 5'd11, 5'd10, 5'b10000}) begin
      nerr++; $display("FAIL add got op %h rs1 %0d rs2 %0d rd %0d rw %b ill %b", bus.alu_op_o, bus.rs1_o,
                       bus.rs2_o, bus.rd_o, bus.reg_write_o, bus.illegal_o);
    end
    offer(32'h40B50533, 32'h104);
    nvec++;
    if ({bus.alu_op_o, bus.illegal_o, bus.pc_o} !== {4'h1, 1'b0, 32'h104}) begin
      nerr++; $display("FAIL sub got op %h ill %b pc %h exp op 1 ill 0 pc 104", bus.alu_op_o, bus.illegal_o, bus.pc_o);
    end
    offer(32'hFFC12083, 32'h108);
    nvec++;
    if ({bus.mem_read_o, bus.reg_write_o, bus.mem_funct3_o, bus.alu_op_o, bus.alu_src_imm_o, bus.illegal_o,
         bus.rs1_o, bus.rd_o} !== {2'b11, 3'b010, 4'h0, 2'b10, 5'd2, 5'd1}) begin
      nerr++; $display("FAIL lw_ctl got mr %b f3 %b op %h ill %b rs1 %0d rd %0d", bus.mem_read_o,
                       bus.mem_funct3_o, bus.alu_op_o, bus.illegal_o, bus.rs1_o, bus.rd_o);
    end
    nvec++;
    if (bus.imm_o !== 32'hFFFFFFFC) begin
      nerr++; $display("FAIL lw_imm got %h exp fffffffc", bus.imm_o);
    end
    offer(32'h00000073, 32'h10C);
    nvec++;
    if ({bus.illegal_o, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.branch_o, bus.jal_o, bus.jalr_o,
         bus.pc_o} !== {7'b1000000, 32'h10C}) begin
      nerr++; $display("FAIL system got ill %b rw %b pc %h exp ill 1 rw 0 pc 10c", bus.illegal_o, bus.reg_write_o, bus.pc_o);
    end
    offer(32'h0020A133, 32'h110);
    nvec++;
    if ({bus.illegal_o, bus.reg_write_o} !== 2'b10) begin
      nerr++; $display("FAIL slt got ill %b rw %b exp ill 1 rw 0", bus.illegal_o, bus.reg_write_o);
    end
    offer(32'h00209093, 32'h114);
    nvec++;
`ifdef RISCV_SHIFT_OPS_EN
    if ({bus.illegal_o, bus.alu_op_o, bus.reg_write_o, bus.alu_src_imm_o, bus.imm_o} !== {1'b0, 4'b0101, 2'b11, 32'd2}) begin
      nerr++; $display("FAIL slli got ill %b op %h imm %h exp ill 0 op 5 imm 2", bus.illegal_o, bus.alu_op_o, bus.imm_o);
    end
`else
    if ({bus.illegal_o, bus.reg_write_o} !== 2'b10) begin
      nerr++; $display("FAIL slli got ill %b rw %b exp ill 1 rw 0", bus.illegal_o, bus.reg_write_o);
    end
`endif
    offer(32'h00B50463, 32'h118);
    nvec++;
    if ({bus.branch_o, bus.alu_op_o, bus.alu_src_imm_o, bus.reg_write_o, bus.illegal_o, bus.mem_funct3_o,
         bus.imm_o} !== {1'b1, 4'h1, 3'b000, 3'b000, 32'd8}) begin
      nerr++; $display("FAIL beq got br %b op %h imm %h ill %b exp br 1 op 1 imm 8", bus.branch_o, bus.alu_op_o,
                       bus.imm_o, bus.illegal_o);
    end
    offer(32'h12345537, 32'h11C);
    nvec++;
    if ({bus.lui_o, bus.rs1_o, bus.rd_o, bus.reg_write_o, bus.alu_src_imm_o, bus.illegal_o, bus.imm_o} !==
        {1'b1, 5'd0, 5'd10, 3'b110, 32'h12345000}) begin
      nerr++; $display("FAIL lui got lui %b rs1 %0d rd %0d imm %h", bus.lui_o, bus.rs1_o, bus.rd_o, bus.imm_o);
    end
    offer(32'hFFDFF06F, 32'h120);
    nvec++;
    if ({bus.jal_o, bus.rd_o, bus.reg_write_o, bus.illegal_o, bus.imm_o} !== {1'b1, 5'd0, 2'b10, 32'hFFFFFFFC}) begin
      nerr++; $display("FAIL jal got jal %b rw %b imm %h exp jal 1 rw 1 imm fffffffc", bus.jal_o, bus.reg_write_o, bus.imm_o);
    end
    offer(32'h00112223, 32'h124);
    nvec++;
    if ({bus.mem_write_o, bus.rs2_o, bus.illegal_o, bus.reg_write_o, bus.imm_o} !== {1'b1, 5'd1, 2'b00, 32'd4}) begin
      nerr++; $display("FAIL sw got mw %b rs2 %0d ill %b imm %h exp mw 1 rs2 1 imm 4", bus.mem_write_o, bus.rs2_o,
                       bus.illegal_o, bus.imm_o);
    end
    offer(32'h00113023, 32'h128);
    nvec++;
    if ({bus.illegal_o, bus.mem_write_o} !== 2'b10) begin
      nerr++; $display("FAIL sd got ill %b mw %b exp ill 1 mw 0", bus.illegal_o, bus.mem_write_o);
    end
    offer(32'h000080E7, 32'h12C);
    nvec++;
    if ({bus.jalr_o, bus.reg_write_o, bus.illegal_o} !== 3'b110) begin
      nerr++; $display("FAIL jalr got %b exp 110", {bus.jalr_o, bus.reg_write_o, bus.illegal_o});
    end
    offer(32'h000090E7, 32'h130);
    nvec++;
    if ({bus.jalr_o, bus.reg_write_o, bus.illegal_o} !== 3'b001) begin
      nerr++; $display("FAIL jalr_f3 got %b exp 001", {bus.jalr_o, bus.reg_write_o, bus.illegal_o});
    end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.instr_i = 32'h00B50533;
    bus.pc_i = 32'h300;
    @(posedge clk);
    #1 bus.instr_i = 32'h40B50533;
    bus.pc_i = 32'h304;
    @(negedge clk);
    nvec++;
    if (bus.in_ready_o !== 1'b1) begin
      nerr++; $display("FAIL bp_ready1 got %b exp 1", bus.in_ready_o);
    end
    @(posedge clk);
    #1 bus.instr_i = 32'hFFC12083;
    bus.pc_i = 32'h308;
    @(negedge clk);
    nvec++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.pc_o} !== {2'b01, 32'h300}) begin
      nerr++; $display("FAIL bp_full got r%b v%b pc %h exp r0 v1 pc 300", bus.in_ready_o, bus.out_valid_o, bus.pc_o);
    end
    @(negedge clk);
    nvec++;
    if ({bus.in_ready_o, bus.pc_o, bus.alu_op_o} !== {1'b0, 32'h300, 4'h0}) begin
      nerr++; $display("FAIL bp_hold got r%b pc %h op %h exp r0 pc 300 op 0", bus.in_ready_o, bus.pc_o, bus.alu_op_o);
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    nvec++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.pc_o, bus.alu_op_o} !== {2'b11, 32'h304, 4'h1}) begin
      nerr++; $display("FAIL bp_second got r%b pc %h op %h exp r1 pc 304 op 1", bus.in_ready_o, bus.pc_o, bus.alu_op_o);
    end
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
    @(negedge clk);
    nvec++;
    if ({bus.out_valid_o, bus.pc_o, bus.mem_read_o} !== {1'b1, 32'h308, 1'b1}) begin
      nerr++; $display("FAIL bp_third got v%b pc %h mr %b exp v1 pc 308 mr 1", bus.out_valid_o, bus.pc_o, bus.mem_read_o);
    end
    @(negedge clk);
    nvec++;
    if (bus.out_valid_o !== 1'b0) begin
      nerr++; $display("FAIL bp_drain got v%b exp v0", bus.out_valid_o);
    end
  endtask
  task automatic test_flush;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.instr_i = 32'h00B50533;
    bus.pc_i = 32'h400;
    @(posedge clk);
    #1 bus.pc_i = 32'h404;
    @(posedge clk);
    #1 bus.pc_i = 32'h408;
    flush = 1'b1;
    @(negedge clk);
    nvec++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.pc_o} !== {2'b01, 32'h400}) begin
      nerr++; $display("FAIL fl_pre got r%b v%b pc %h exp r0 v1 pc 400", bus.in_ready_o, bus.out_valid_o, bus.pc_o);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    nvec++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin
      nerr++; $display("FAIL fl_next got v%b r%b exp v0 r1", bus.out_valid_o, bus.in_ready_o);
    end
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (bus.out_valid_o !== 1'b0) begin
        nerr++; $display("FAIL fl_quiet%0d got v%b pc %h exp v0", i, bus.out_valid_o, bus.pc_o);
      end
    end
  endtask
  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
